proc_mem_port_arbiter: RTL and testbench



---
 rtl/proc_mem_port_arbiter_if.sv | 51 +++++
 rtl/proc_mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_proc_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_mem_port_arbiter_if.sv
// Message types and the val/rdy memory-port interface shared by proc, arbiter and memory.
// The master side issues requests and accepts responses; the slave side is the memory.
package proc_mem_pkg;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

interface proc_mem_port_arbiter_if;
    import proc_mem_pkg::*;

    mem_req_4B_t  req_msg;
    logic         req_val;
    logic         req_rdy;
    mem_resp_4B_t resp_msg;
    logic         resp_val;
    logic         resp_rdy;

    modport master (
        output req_msg,
        output req_val,
        input  req_rdy,
        input  resp_msg,
        input  resp_val,
        output resp_rdy
    );

    modport slave (
        input  req_msg,
        input  req_val,
        output req_rdy,
        output resp_msg,
        output resp_val,
        input  resp_rdy
    );

endinterface

// File: rtl/proc_mem_port_arbiter.sv
// Shares one 4B memory port between imem and dmem; 0-cycle request mux, in-order response steering via an ID FIFO.
// PROC_MEM_ARB_DMEM_PRIO_EN selects fixed dmem priority instead of round-robin.
module proc_mem_port_arbiter #(
    parameter int p_max_inflight = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    proc_mem_port_arbiter_if.slave            imem_i,
    proc_mem_port_arbiter_if.slave            dmem_i,
    proc_mem_port_arbiter_if.master           mem_o,
    output logic [$clog2(p_max_inflight):0]   inflight_cnt
);

    localparam int PW = $clog2(p_max_inflight);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(p_max_inflight);

    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [p_max_inflight-1:0] id_q, id_d;

    logic grant;     // 0 = imem, 1 = dmem
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_id;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign head_id = id_q[rd_ptr_q];

`ifdef PROC_MEM_ARB_DMEM_PRIO_EN
    always_comb begin
        grant = dmem_i.req_val;
    end
`else
    logic last_grant_q, last_grant_d;

    // Alternate on contention; a lone requester is granted outright.
    always_comb begin
        if (imem_i.req_val && dmem_i.req_val) begin
            grant = ~last_grant_q;
        end else begin
            grant = dmem_i.req_val;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (push) begin
            last_grant_d = grant;
        end
    end

    // Reset to dmem so imem wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Request path: combinational pass-through of the granted port.
    always_comb begin
        mem_o.req_val  = (imem_i.req_val | dmem_i.req_val) & ~full;
        mem_o.req_msg  = grant ? dmem_i.req_msg : imem_i.req_msg;
        imem_i.req_rdy = ~grant & mem_o.req_rdy & ~full;
        dmem_i.req_rdy =  grant & mem_o.req_rdy & ~full;
    end

    assign push = mem_o.req_val & mem_o.req_rdy;

    // Response path: the oldest in-flight ID owns the memory response.
    always_comb begin
        imem_i.resp_msg = mem_o.resp_msg;
        dmem_i.resp_msg = mem_o.resp_msg;
        imem_i.resp_val = mem_o.resp_val & ~empty & ~head_id;
        dmem_i.resp_val = mem_o.resp_val & ~empty &  head_id;
        mem_o.resp_rdy  = ~empty & (head_id ? dmem_i.resp_rdy : imem_i.resp_rdy);
    end

    assign pop = mem_o.resp_val & mem_o.resp_rdy;

    // A pop cannot free a slot for a push in the same cycle, so cnt never exceeds the depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        if (push) begin
            id_d[wr_ptr_q] = grant;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
        end
    end

    assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_proc_mem_port_arbiter.sv
// Scoreboard bench for proc_mem_port_arbiter: stimulus pushes expected grants/responses, a negedge monitor checks them.
module tb_proc_mem_port_arbiter;
    import proc_mem_pkg::*;

`ifdef PROC_MEM_ARB_DMEM_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] inflight_cnt;

    always #5 clk = ~clk;

    proc_mem_port_arbiter_if imem_if ();
    proc_mem_port_arbiter_if dmem_if ();
    proc_mem_port_arbiter_if mem_if ();

    proc_mem_port_arbiter #(.p_max_inflight(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_i       (imem_if),
        .dmem_i       (dmem_if),
        .mem_o        (mem_if),
        .inflight_cnt (inflight_cnt)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_req_q[$];
    exp_t        exp_resp_q[$];
    logic [31:0] mem_q[$];
    int          resp_budget = 0;
    bit          stray = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic port, input logic [31:0] addr);
        exp_t e;
        e.port = port;
        e.val  = addr;
        exp_req_q.push_back(e);
        e.val  = rdata(addr);
        exp_resp_q.push_back(e);
    endtask

    task automatic drive(input bit iv, input logic [31:0] ia, input bit dv, input logic [31:0] da);
        imem_if.req_val      = iv;
        imem_if.req_msg      = '0;
        imem_if.req_msg.addr = ia;
        dmem_if.req_val      = dv;
        dmem_if.req_msg      = '0;
        dmem_if.req_msg.addr = da;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_left(input int n, input string name);
        int k = 0;
        while (exp_resp_q.size() > n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(name, exp_resp_q.size(), n);
    endtask

    task automatic start_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        mem_if.resp_val = 1'b0;
        resp_budget = 0;
        mem_q.delete();
        exp_req_q.delete();
        exp_resp_q.delete();
    endtask

    // Memory model: answers accepted requests in order, one per cycle while budget allows.
    always begin
        @(posedge clk);
        #1;
        mem_if.resp_msg = '0;
        if (reset) begin
            mem_if.resp_val = 1'b0;
        end else if (mem_q.size() > 0 && resp_budget > 0) begin
            mem_if.resp_val      = 1'b1;
            mem_if.resp_msg.data = rdata(mem_q[0]);
        end else if (stray) begin
            mem_if.resp_val      = 1'b1;
            mem_if.resp_msg.data = 32'h0BAD_0BAD;
        end else begin
            mem_if.resp_val = 1'b0;
        end
    end

    // Monitor: every handshake is checked against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic port;
        if (!reset) begin
            if (mem_if.resp_val) begin
                chk("resp_one_val", {31'b0, imem_if.resp_val & dmem_if.resp_val}, 32'd0);
            end
            if (mem_if.resp_val && mem_if.resp_rdy) begin
                port = dmem_if.resp_val;
                chk("resp_any_val", {31'b0, imem_if.resp_val | dmem_if.resp_val}, 32'd1);
                if (exp_resp_q.size() == 0) begin
                    chk("resp_unexpected", exp_resp_q.size(), 32'd1);
                end else begin
                    e = exp_resp_q.pop_front();
                    chk("resp_port", {31'b0, port}, {31'b0, e.port});
                    chk("resp_data", port ? dmem_if.resp_msg.data : imem_if.resp_msg.data, e.val);
                end
                if (mem_q.size() > 0) void'(mem_q.pop_front());
                if (resp_budget > 0) resp_budget--;
            end
            if (mem_if.req_val && mem_if.req_rdy) begin
                port = dmem_if.req_rdy;
                chk("req_one_rdy", {31'b0, imem_if.req_rdy ^ dmem_if.req_rdy}, 32'd1);
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", exp_req_q.size(), 32'd1);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_port", {31'b0, port}, {31'b0, e.port});
                    chk("req_addr", mem_if.req_msg.addr, e.val);
                end
                mem_q.push_back(mem_if.req_msg.addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0);
        mem_if.req_rdy   = 1'b0;
        mem_if.resp_val  = 1'b0;
        mem_if.resp_msg  = '0;
        imem_if.resp_rdy = 1'b1;
        dmem_if.resp_rdy = 1'b1;

        // Reset state; memreq_val still follows the request valids.
        start_reset();
        imem_if.req_val = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", inflight_cnt, 32'd0);
        chk("rst_memresp_rdy", mem_if.resp_rdy, 32'd0);
        chk("rst_imemresp_val", imem_if.resp_val, 32'd0);
        chk("rst_dmemresp_val", dmem_if.resp_val, 32'd0);
        chk("rst_memreq_val", mem_if.req_val, 32'd1);
        cyc();
        reset = 1'b0;
        drive(0, 0, 0, 0);

        // Stray response with an empty FIFO is held off and not forwarded.
        stray = 1'b1;
        cyc();
        @(negedge clk);
        chk("stray_memresp_rdy", mem_if.resp_rdy, 32'd0);
        chk("stray_imemresp_val", imem_if.resp_val, 32'd0);
        chk("stray_dmemresp_val", dmem_if.resp_val, 32'd0);
        stray = 1'b0;
        cyc();

        // Single imem request passes straight through and its response returns to imem.
        mem_if.req_rdy = 1'b1;
        expect_txn(1'b0, 32'h0000_0200);
        drive(1, 32'h0000_0200, 0, 0);
        @(negedge clk);
        chk("single_addr", mem_if.req_msg.addr, 32'h0000_0200);
        chk("single_imemreq_rdy", imem_if.req_rdy, 32'd1);
        chk("single_dmemreq_rdy", dmem_if.req_rdy, 32'd0);
        cyc();
        drive(0, 0, 0, 0);
        resp_budget = 100;
        wait_left(0, "single_drain");
        cyc();

        // Both ports valid every cycle right after reset: I,D,I,D (or all D with dmem priority).
        start_reset();
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_txn(PRIO ? 1'b1 : k[0], (PRIO || k[0]) ? 32'h0000_2000 : 32'h0000_1000);
        end
        resp_budget = 100;
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h0000_1000, 1, 32'h0000_2000);
            cyc();
        end
        drive(0, 0, 0, 0);
        wait_left(0, "rr_drain");
        cyc();

        // Reset mid-burst with three requests outstanding.
        resp_budget = 0;
        for (int k = 0; k < 3; k++) begin
            expect_txn(1'b0, 32'h0000_0700 + 32'(k));
            drive(1, 32'h0000_0700 + 32'(k), 0, 0);
            cyc();
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("burst_cnt", inflight_cnt, 32'd3);
        cyc();
        start_reset();
        @(negedge clk);
        chk("midrst_cnt", inflight_cnt, 32'd0);
        chk("midrst_memresp_rdy", mem_if.resp_rdy, 32'd0);
        cyc();
        reset = 1'b0;
        expect_txn(PRIO, PRIO ? 32'h0000_0600 : 32'h0000_0200);
        drive(1, 32'h0000_0200, 1, 32'h0000_0600);
        cyc();
        drive(0, 0, 0, 0);
        resp_budget = 100;
        wait_left(0, "midrst_drain");
        cyc();

        // Fill to depth, check full blocking, then one pop lets the next request in a cycle later.
        resp_budget = 0;
        for (int k = 0; k < 4; k++) begin
            expect_txn(1'b0, 32'h0000_0300 + 32'(k));
            drive(1, 32'h0000_0300 + 32'(k), 0, 0);
            cyc();
        end
        expect_txn(1'b1, 32'h0000_0504);
        drive(1, 32'h0000_0304, 1, 32'h0000_0504);
        @(negedge clk);
        chk("full_cnt", inflight_cnt, 32'd4);
        chk("full_memreq_val", mem_if.req_val, 32'd0);
        chk("full_imemreq_rdy", imem_if.req_rdy, 32'd0);
        chk("full_dmemreq_rdy", dmem_if.req_rdy, 32'd0);
        resp_budget = 1;
        cyc();
        @(negedge clk);
        chk("full_pop_rdy", mem_if.resp_rdy, 32'd1);
        chk("full_no_bypass", mem_if.req_val, 32'd0);
        cyc();
        @(negedge clk);
        chk("resume_memreq_val", mem_if.req_val, 32'd1);
        chk("resume_cnt", inflight_cnt, 32'd3);
        cyc();
        drive(0, 0, 0, 0);
        resp_budget = 100;
        wait_left(0, "full_drain");
        cyc();

        // I,D,I outstanding; dmem stalls at the head, then responses resume in order.
        resp_budget = 0;
        expect_txn(1'b0, 32'h0000_0400);
        drive(1, 32'h0000_0400, 0, 0);
        cyc();
        expect_txn(1'b1, 32'h0000_0500);
        drive(0, 0, 1, 32'h0000_0500);
        cyc();
        expect_txn(1'b0, 32'h0000_0404);
        drive(1, 32'h0000_0404, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        dmem_if.resp_rdy = 1'b0;
        resp_budget = 100;
        wait_left(2, "stall_first_pop");
        cyc();
        @(negedge clk);
        chk("stall_memresp_rdy", mem_if.resp_rdy, 32'd0);
        chk("stall_dmemresp_val", dmem_if.resp_val, 32'd1);
        chk("stall_imemresp_val", imem_if.resp_val, 32'd0);
        chk("stall_cnt", inflight_cnt, 32'd2);
        cyc();
        @(negedge clk);
        chk("stall_hold_cnt", inflight_cnt, 32'd2);
        cyc();
        dmem_if.resp_rdy = 1'b1;
        wait_left(0, "stall_drain");
        cyc();

        @(negedge clk);
        chk("end_cnt", inflight_cnt, 32'd0);
        chk("end_req_left", exp_req_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
